// File: rtl/ddr3_ba_delay_ctrl.sv
// ============================================================================
// Module   : ddr3_ba_delay_ctrl
// Purpose  : Tap-adjust sequencer for the DDR3 bank-address IOD TX delay lines.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ddr3_ba_delay_ctrl #(
  parameter int NUM_LANES  = 3,
  parameter int TAP_W      = 8,
  parameter int MAX_TAP    = 127,
  parameter int INIT_TAP   = 1,
  parameter int SETTLE_CYC = 4
) (
  input  logic                       FAB_CLK,
  input  logic                       ARST_N,
  input  logic                       REQ_VALID,
  output logic                       REQ_READY,
  input  logic [1:0]                 REQ_LANE,
  input  logic [1:0]                 REQ_OP,
  input  logic [TAP_W-1:0]           REQ_VAL,
  output logic                       RSP_VALID,
  output logic [1:0]                 RSP_STATUS,
  output logic [TAP_W-1:0]           RSP_TAP,
  output logic [NUM_LANES-1:0]       DELAY_LINE_MOVE,
  output logic [NUM_LANES-1:0]       DELAY_LINE_DIRECTION,
  output logic [NUM_LANES-1:0]       DELAY_LINE_LOAD,
  input  logic [NUM_LANES-1:0]       DELAY_LINE_OUT_OF_RANGE,
  output logic [NUM_LANES*TAP_W-1:0] TAP_CNT,
  output logic                       BUSY
);

  localparam logic [1:0]       c_OP_LOAD     = 2'b00;
  localparam logic [1:0]       c_OP_INC      = 2'b01;
  localparam logic [1:0]       c_OP_SET      = 2'b11;
  localparam logic [1:0]       c_ST_OK       = 2'b00;
  localparam logic [1:0]       c_ST_RANGE    = 2'b01;
  localparam logic [1:0]       c_ST_LANE     = 2'b10;
  localparam logic [TAP_W-1:0] c_MAX         = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] c_INIT        = TAP_W'(INIT_TAP);
  localparam logic [TAP_W-1:0] c_ONE         = TAP_W'(1);
  localparam logic [3:0]       c_SETTLE_INIT = 4'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOADP  = 3'd1,
    S_SETUP  = 3'd2,
    S_PULSE  = 3'd3,
    S_SETTLE = 3'd4,
    S_CHECK  = 3'd5,
    S_RESP   = 3'd6
  } state_t;

  state_t                 r_state, w_next;
  logic                   r_live;
  logic [1:0]             r_lane;
  logic [1:0]             r_op;
  logic [TAP_W-1:0]       r_steps;
  logic [TAP_W-1:0]       r_target;
  logic                   r_inc;
  logic                   r_loading;
  logic [1:0]             r_status;
  logic [3:0]             r_settle;
  logic [NUM_LANES-1:0]   r_dir;
  logic [TAP_W-1:0]       r_tap [NUM_LANES];

  logic                   w_accept, w_req_lane_ok, w_lane_ok, w_oor;
  logic                   w_at_bound, w_new_bound, w_settle_done, w_abs_inc;
  logic [TAP_W-1:0]       w_cur_tap, w_next_tap, w_abs_steps, w_req_target;
  logic [NUM_LANES-1:0]   w_move, w_load, w_dir;

  assign w_accept      = REQ_VALID & REQ_READY;
  assign w_req_lane_ok = int'(REQ_LANE) < NUM_LANES;
  assign w_lane_ok     = int'(r_lane) < NUM_LANES;
  assign w_req_target  = (REQ_VAL > c_MAX) ? c_MAX : REQ_VAL;
  assign w_cur_tap     = w_lane_ok ? r_tap[r_lane] : '0;
  assign w_oor         = w_lane_ok & DELAY_LINE_OUT_OF_RANGE[r_lane];
  assign w_next_tap    = r_inc ? (w_cur_tap + c_ONE) : (w_cur_tap - c_ONE);
  assign w_at_bound    = r_inc ? (w_cur_tap == c_MAX) : (w_cur_tap == '0);
  assign w_new_bound   = r_inc ? (w_next_tap == c_MAX) : (w_next_tap == '0);
  assign w_settle_done = (r_settle == 4'd0);
  // Set-absolute always steps from the post-load tap value.
  assign w_abs_inc     = r_target > c_INIT;
  assign w_abs_steps   = w_abs_inc ? (r_target - c_INIT) : (c_INIT - r_target);

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_move = '0;
    w_load = '0;
    w_dir  = r_dir;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_req_lane_ok)                              w_next = S_RESP;
          else if (REQ_OP == c_OP_LOAD || REQ_OP == c_OP_SET) w_next = S_LOADP;
          else if (REQ_VAL == '0)                          w_next = S_RESP;
          else                                             w_next = S_SETUP;
        end
      end
      S_LOADP: begin
        w_load[r_lane] = 1'b1;
        w_next         = S_SETTLE;
      end
      S_SETUP: begin
        w_dir[r_lane] = r_inc;
        w_next        = w_at_bound ? S_RESP : S_PULSE;
      end
      S_PULSE: begin
        w_move[r_lane] = 1'b1;
        w_next         = S_SETTLE;
      end
      S_SETTLE: begin
        if (w_settle_done) begin
          if (!r_loading)                                  w_next = S_CHECK;
          else if (r_op == c_OP_SET && w_abs_steps != '0) w_next = S_SETUP;
          else                                             w_next = S_RESP;
        end
      end
      S_CHECK: begin
        if (w_oor || r_steps == c_ONE || w_new_bound) w_next = S_RESP;
        else                                          w_next = S_PULSE;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      r_live    <= 1'b0;
      r_lane    <= '0;
      r_op      <= '0;
      r_steps   <= '0;
      r_target  <= '0;
      r_inc     <= 1'b0;
      r_loading <= 1'b0;
      r_status  <= c_ST_OK;
      r_settle  <= '0;
      r_dir     <= '0;
      for (int i = 0; i < NUM_LANES; i++) r_tap[i] <= c_INIT;
    end else begin
      r_live <= 1'b1;
      if (r_state != S_SETTLE && w_next == S_SETTLE) r_settle <= c_SETTLE_INIT;
      else if (r_state == S_SETTLE && !w_settle_done) r_settle <= r_settle - 4'd1;

      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_lane    <= REQ_LANE;
            r_op      <= REQ_OP;
            r_steps   <= REQ_VAL;
            r_target  <= w_req_target;
            r_inc     <= (REQ_OP == c_OP_INC);
            r_loading <= (REQ_OP == c_OP_LOAD) || (REQ_OP == c_OP_SET);
            if (!w_req_lane_ok)                          r_status <= c_ST_LANE;
            else if (REQ_OP == c_OP_SET && REQ_VAL > c_MAX) r_status <= c_ST_RANGE;
            else                                         r_status <= c_ST_OK;
          end
        end
        S_SETTLE: begin
          if (w_settle_done && r_loading) begin
            r_tap[r_lane] <= c_INIT;
            r_loading     <= 1'b0;
            if (r_op == c_OP_SET) begin
              r_steps <= w_abs_steps;
              r_inc   <= w_abs_inc;
            end
          end
        end
        S_SETUP: begin
          r_dir[r_lane] <= r_inc;
          if (w_at_bound) r_status <= c_ST_RANGE;
        end
        S_CHECK: begin
          if (w_oor) begin
            r_status <= c_ST_RANGE;
          end else begin
            r_tap[r_lane] <= w_next_tap;
            r_steps       <= r_steps - c_ONE;
            // Landing on a limit with steps still pending is a range stop.
            if (r_steps != c_ONE && w_new_bound) r_status <= c_ST_RANGE;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_tap
    assign TAP_CNT[gi*TAP_W +: TAP_W] = r_tap[gi];
  end

  assign REQ_READY            = r_live & (r_state == S_IDLE);
  assign BUSY                 = (r_state != S_IDLE);
  assign RSP_VALID            = (r_state == S_RESP);
  assign RSP_STATUS           = RSP_VALID ? r_status : 2'b00;
  assign RSP_TAP              = RSP_VALID ? w_cur_tap : '0;
  assign DELAY_LINE_MOVE      = w_move;
  assign DELAY_LINE_LOAD      = w_load;
  assign DELAY_LINE_DIRECTION = w_dir;

endmodule

`default_nettype wire

// File: doc/ddr3_ba_delay_ctrl.md
# ddr3_ba_delay_ctrl

Sequencer for the dynamic TX delay lines of the DDR3 bank-address IOD lanes. It accepts tap-adjust commands from the PHY training logic over a valid/ready request port. It converts each command into correctly spaced DELAY_LINE_LOAD, MOVE and DIRECTION pulses for one lane, and keeps a per-lane tap count. It sits in the FAB_CLK domain between the training FSM and the BA IOD block.

## Interface
- NUM_LANES, 3: number of IOD lanes controlled (BA0..BA2).
- TAP_W, 8: tap count / request value width.
- MAX_TAP, 127: highest legal tap count.
- INIT_TAP, 1: tap value the IOD takes after a LOAD; matches the IOD static TX delay value.
- SETTLE_CYC, 4: idle cycles after each MOVE/LOAD pulse before the next action; legal range 1..15.

Ports:
- FAB_CLK  in  1  single clock; all logic on its rising edge.
- ARST_N  in  1  reset; asynchronous, active-low.
- REQ_VALID  in  1  command valid.
- REQ_READY  out  1  command accepted when REQ_VALID & REQ_READY.
- REQ_LANE  in  2  target lane index.
- REQ_OP  in  2  opcode: 00 load, 01 increment by REQ_VAL, 10 decrement by REQ_VAL, 11 set absolute REQ_VAL.
- REQ_VAL  in  TAP_W  step count or absolute target.
- RSP_VALID  out  1  one-cycle completion pulse.
- RSP_STATUS  out  2  00 ok, 01 range-limited, 10 bad lane; valid with RSP_VALID.
- RSP_TAP  out  TAP_W  lane tap count after the command; valid with RSP_VALID.
- DELAY_LINE_MOVE  out  NUM_LANES  per-lane move pulse.
- DELAY_LINE_DIRECTION  out  NUM_LANES  per-lane direction; 1 means increase delay.
- DELAY_LINE_LOAD  out  NUM_LANES  per-lane load pulse.
- DELAY_LINE_OUT_OF_RANGE  in  NUM_LANES  per-lane IOD range flag; synchronous to FAB_CLK.
- TAP_CNT  out  NUM_LANES*TAP_W  packed per-lane tap counts; lane i occupies bits [i*TAP_W +: TAP_W].
- BUSY  out  1  high in every state except IDLE.

## Operation
- States: IDLE, LOADP, SETUP, PULSE, SETTLE, CHECK, RESP.
- REQ_READY is 1 only in IDLE. The opcode, lane and value are captured on acceptance.
- REQ_LANE >= NUM_LANES: go to RESP with status 10. No pulses are issued and no count changes.
- Load (00):
  - LOADP drives a 1-cycle DELAY_LINE_LOAD[lane], followed by SETTLE.
  - The count is set to INIT_TAP, then the FSM goes to RESP.
- Increment/decrement (01/10):
  - A remaining-step counter is loaded with REQ_VAL. If REQ_VAL = 0, go directly to RESP with status 00.
  - SETUP drives DIRECTION[lane] (1 for increment, 0 for decrement). DIRECTION holds until the next command on that lane.
  - PULSE drives a 1-cycle MOVE[lane], followed by SETTLE for SETTLE_CYC cycles, then CHECK.
  - In CHECK, if OUT_OF_RANGE[lane] = 1, the count is unchanged and the FSM goes to RESP with status 01.
  - Otherwise the count changes by ±1 and the remaining-step counter decrements. If steps remain, go to PULSE; else go to RESP with status 00.
  - Software bound: before any PULSE, if the count = MAX_TAP (increment) or 0 (decrement), go to RESP with status 01 without issuing the pulse.
- Set absolute (11):
  - Perform a Load, then step from INIT_TAP toward min(REQ_VAL, MAX_TAP) using the increment/decrement path.
  - Status is 01 if REQ_VAL > MAX_TAP or if range-limited during stepping.
- OUT_OF_RANGE on non-selected lanes is ignored. MOVE and LOAD on non-selected lanes stay 0.
- RESP drives RSP_VALID for one cycle with RSP_TAP = the lane's count, then returns to IDLE.

## Timing
- Reset values:
  - REQ_READY = 0 while ARST_N is low, and 1 from the first cycle after release.
  - RSP_VALID, RSP_STATUS, RSP_TAP, MOVE, LOAD, DIRECTION and BUSY are all 0.
  - Every TAP_CNT lane equals INIT_TAP.
- Reset asserted mid-command: all outputs go to reset values immediately. The in-flight command is dropped and no response is issued.
- For a command accepted in cycle N:
  - Step of n ≥ 1 taps: MOVE for step k (k = 0..n-1) is in cycle N+2+k*(2+SETTLE_CYC). RSP_VALID is in cycle N+2+n*(2+SETTLE_CYC).
  - Load: LOAD in N+1, RSP_VALID in N+2+SETTLE_CYC.
  - Zero step or bad lane: RSP_VALID in N+1.
- MOVE and LOAD never assert in the same cycle. Consecutive pulses on a lane are separated by at least SETTLE_CYC+1 cycles.
- TAP_CNT updates at the end of the CHECK cycle (load: end of the last SETTLE cycle).
- The earliest next acceptance is the cycle after RSP_VALID.

## Test plan
- Reset, then increment lane 1 by 3 with SETTLE_CYC = 4 (accepted in cycle N) -> DIRECTION[1] = 1 from N+1, MOVE[1] pulses at N+2/N+8/N+14, RSP at N+20 with status 00 and tap 4.
- Decrement lane 0 by 5 from a count of 2 -> 2 MOVE pulses, then RSP status 01 with tap 0 and no third pulse.
- Increment lane 2 by 10 with OUT_OF_RANGE[2] forced to 1 after the 4th move -> 4 pulses, RSP status 01, tap 4 (1+3).
- Set absolute lane 0 to 200 -> LOAD[0] at N+1, then 126 increment pulses, RSP status 01 with tap 127.
- REQ_LANE = 3 -> RSP at N+1 with status 10, no MOVE/LOAD activity and all counts unchanged. A REQ_VALID held during BUSY is not accepted until IDLE.
- ARST_N pulsed low mid-way through a 6-step increment -> outputs clear immediately, TAP_CNT returns to INIT_TAP, no RSP; the next command completes normally.
